// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester-side bundle (req/lock/data) plus the shared register outputs.
// Latency: none, this file is wiring only.
// Backpressure: none; requesters hold i_req until they observe their o_gnt bit.
// Ports (signals): i_req/i_lock [NUM_REQ], i_data [NUM_REQ*DATA_W], o_gnt [NUM_REQ], o_gnt_valid,
//   o_owner [$clog2(NUM_REQ)], o_q/o_qbar [DATA_W].
//   With REG_WRITE_STATS_EN defined: o_write_cnt [16], o_hold_abort.
// Modports: master = requester/producer side, slave = arbiter side.
interface reg_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int OWN_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ-1:0]        i_lock;
  logic [NUM_REQ*DATA_W-1:0] i_data;
  logic [NUM_REQ-1:0]        o_gnt;
  logic                      o_gnt_valid;
  logic [OWN_W-1:0]          o_owner;
  logic [DATA_W-1:0]         o_q;
  logic [DATA_W-1:0]         o_qbar;
`ifdef REG_WRITE_STATS_EN
  logic [15:0]               o_write_cnt;
  logic                      o_hold_abort;

  modport master (
    output i_req, i_lock, i_data,
    input  o_gnt, o_gnt_valid, o_owner, o_q, o_qbar, o_write_cnt, o_hold_abort
  );
  modport slave (
    input  i_req, i_lock, i_data,
    output o_gnt, o_gnt_valid, o_owner, o_q, o_qbar, o_write_cnt, o_hold_abort
  );
`else
  modport master (
    output i_req, i_lock, i_data,
    input  o_gnt, o_gnt_valid, o_owner, o_q, o_qbar
  );
  modport slave (
    input  i_req, i_lock, i_data,
    output o_gnt, o_gnt_valid, o_owner, o_q, o_qbar
  );
`endif
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin owner of a shared true/complement register pair.
// Latency: grant 1 cycle after i_req sampled; owner data visible on o_q 1 cycle after the write edge.
// Backpressure: requesters wait on o_gnt; a locked owner may hold up to MAX_HOLD consecutive cycles.
// Ports: i_clk, i_rst (sync, active high), bus (reg_write_arbiter_if.slave) carrying i_req, i_lock,
//   i_data, o_gnt, o_gnt_valid, o_owner, o_q, o_qbar.
// Optional: REG_WRITE_STATS_EN adds o_write_cnt (saturating write count) and o_hold_abort
//   (one-cycle pulse when a locked owner is forced off by the MAX_HOLD limit).
module reg_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  reg_write_arbiter_if.slave  bus
);
  localparam int OWN_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t              state, state_n;
  logic [NUM_REQ-1:0]  gnt, gnt_n;
  logic [OWN_W-1:0]    owner, owner_n;
  logic [OWN_W-1:0]    ptr, ptr_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [DATA_W-1:0]   q, qbar;
  logic                wr_en;

  logic                sel_found;
  logic [OWN_W-1:0]    sel_idx;
  logic                owner_req;
  logic                owner_lock;
  logic [DATA_W-1:0]   owner_data;

  assign owner_req  = bus.i_req[owner];
  assign owner_lock = bus.i_lock[owner];
  assign owner_data = bus.i_data[int'(owner)*DATA_W +: DATA_W];

  // First requester at or above ptr, wrapping. ptr already sits one past the
  // current owner, so the same search serves both IDLE and release-in-OWN, and
  // the current owner is examined last.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && bus.i_req[(int'(ptr) + i) % NUM_REQ]) begin
        sel_found = 1'b1;
        sel_idx   = OWN_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    wr_en   = 1'b0;

    // Release path shared by IDLE and OWN: hand to the winner or fall idle.
    if (state == OWN) begin
      wr_en = owner_req;
    end

    if (state == OWN && owner_req && owner_lock && hold_cnt < HOLD_LAST) begin
      hold_n = hold_cnt + 1'b1;
    end else if (sel_found) begin
      state_n = OWN;
      gnt_n   = NUM_REQ'(1) << sel_idx;
      owner_n = sel_idx;
      hold_n  = '0;
      ptr_n   = (sel_idx == OWN_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end else begin
      state_n = IDLE;
      gnt_n   = '0;
      owner_n = '0;
      hold_n  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      q        <= '0;
      qbar     <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      if (wr_en) begin
        q    <= owner_data;
        qbar <= ~owner_data;
      end
    end
  end

  assign bus.o_gnt       = gnt;
  assign bus.o_gnt_valid = |gnt;
  assign bus.o_owner     = owner;
  assign bus.o_q         = q;
  assign bus.o_qbar      = qbar;

`ifdef REG_WRITE_STATS_EN
  logic [15:0] write_cnt;
  logic        hold_abort;
  logic        limit_release;

  // Only a still-requesting, still-locked owner at the last hold cycle is
  // being cut off; a voluntary drop or unlock is not an abort.
  assign limit_release = (state == OWN) && owner_req && owner_lock && (hold_cnt == HOLD_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      write_cnt  <= '0;
      hold_abort <= 1'b0;
    end else begin
      if (wr_en && write_cnt != 16'hFFFF) begin
        write_cnt <= write_cnt + 16'd1;
      end
      hold_abort <= limit_release;
    end
  end

  assign bus.o_write_cnt  = write_cnt;
  assign bus.o_hold_abort = hold_abort;
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: vector table plus a locked-rotation sequence for reg_write_arbiter.
// Latency: expectations are queued when inputs are driven and compared 1 time unit after the edge.
// Backpressure: n/a; the bench drives requests every cycle.
module tb_reg_write_arbiter;
  typedef struct {
    logic [3:0]  gnt;
    logic [1:0]  own;
    logic [7:0]  q;
    logic [7:0]  qbar;
    logic [15:0] wcnt;
    logic        abort;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] data;
    exp_t        e;
  } vec_t;

  localparam logic [31:0] DEF = 32'h44A52211;  // d3=44 d2=A5 d1=22 d0=11

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  exp_t sb[$];
  vec_t tbl[27];

  reg_write_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  reg_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                              input logic [31:0] d, input logic [3:0] g, input logic [1:0] o,
                              input logic [7:0] q, input logic [7:0] qb,
                              input logic [15:0] wc, input logic ab);
    vec_t v;
    v.rst = r; v.req = rq; v.lock = lk; v.data = d;
    v.e.gnt = g; v.e.own = o; v.e.q = q; v.e.qbar = qb; v.e.wcnt = wc; v.e.abort = ab;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " gnt"},   32'(bus.o_gnt),       32'(e.gnt));
      check({tag, " valid"}, 32'(bus.o_gnt_valid), 32'(e.gnt != 4'd0));
      check({tag, " owner"}, 32'(bus.o_owner),     32'(e.own));
      check({tag, " q"},     32'(bus.o_q),         32'(e.q));
      check({tag, " qbar"},  32'(bus.o_qbar),      32'(e.qbar));
`ifdef REG_WRITE_STATS_EN
      check({tag, " wcnt"},  32'(bus.o_write_cnt),  32'(e.wcnt));
      check({tag, " abort"}, 32'(bus.o_hold_abort), 32'(e.abort));
`endif
    end
  endtask

  task automatic apply(input string tag, input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [31:0] d, input exp_t e);
    @(negedge clk);
    rst        = r;
    bus.i_req  = rq;
    bus.i_lock = lk;
    bus.i_data = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] dv;
    int          own;
    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b1;
    bus.i_req  = '0;
    bus.i_lock = '0;
    bus.i_data = '0;

    //             rst req   lock  data          gnt   own q      qbar   wcnt abort
    tbl[0]  = mk(1, 4'hF, 4'h0, DEF,          4'h0, 0, 8'h00, 8'h00, 0,  0);  // reset with req
    tbl[1]  = mk(1, 4'hF, 4'h0, DEF,          4'h0, 0, 8'h00, 8'h00, 0,  0);
    tbl[2]  = mk(1, 4'hF, 4'h0, DEF,          4'h0, 0, 8'h00, 8'h00, 0,  0);
    tbl[3]  = mk(0, 4'hF, 4'h0, DEF,          4'h1, 0, 8'h00, 8'h00, 0,  0);  // first grant -> 0
    tbl[4]  = mk(0, 4'hF, 4'h0, DEF,          4'h2, 1, 8'h11, 8'hEE, 1,  0);  // rotation
    tbl[5]  = mk(0, 4'hF, 4'h0, DEF,          4'h4, 2, 8'h22, 8'hDD, 2,  0);
    tbl[6]  = mk(0, 4'hF, 4'h0, DEF,          4'h8, 3, 8'hA5, 8'h5A, 3,  0);
    tbl[7]  = mk(0, 4'hF, 4'h0, DEF,          4'h1, 0, 8'h44, 8'hBB, 4,  0);
    tbl[8]  = mk(0, 4'h4, 4'h0, DEF,          4'h4, 2, 8'h44, 8'hBB, 4,  0);  // owner 0 dropped
    tbl[9]  = mk(0, 4'h4, 4'h0, DEF,          4'h4, 2, 8'hA5, 8'h5A, 5,  0);  // sole req re-grant
    tbl[10] = mk(0, 4'h4, 4'h0, DEF,          4'h4, 2, 8'hA5, 8'h5A, 6,  0);
    tbl[11] = mk(0, 4'h0, 4'h0, DEF,          4'h0, 0, 8'hA5, 8'h5A, 6,  0);  // to IDLE
    tbl[12] = mk(0, 4'h0, 4'h0, 32'h44A522FF, 4'h0, 0, 8'hA5, 8'h5A, 6,  0);  // no IDLE write
    tbl[13] = mk(0, 4'h4, 4'h0, DEF,          4'h4, 2, 8'hA5, 8'h5A, 6,  0);
    tbl[14] = mk(0, 4'h4, 4'h0, 32'h443C2211, 4'h4, 2, 8'h3C, 8'hC3, 7,  0);
    tbl[15] = mk(0, 4'hA, 4'h2, DEF,          4'h8, 3, 8'h3C, 8'hC3, 7,  0);
    tbl[16] = mk(0, 4'hA, 4'h2, DEF,          4'h2, 1, 8'h44, 8'hBB, 8,  0);  // locked owner 1
    tbl[17] = mk(0, 4'hA, 4'h2, DEF,          4'h2, 1, 8'h22, 8'hDD, 9,  0);
    tbl[18] = mk(0, 4'hA, 4'h2, 32'h44A52311, 4'h2, 1, 8'h23, 8'hDC, 10, 0);
    tbl[19] = mk(0, 4'hA, 4'h2, 32'h44A52411, 4'h2, 1, 8'h24, 8'hDB, 11, 0);
    tbl[20] = mk(0, 4'hA, 4'h2, 32'h44A52511, 4'h8, 3, 8'h25, 8'hDA, 12, 1);  // hold limit
    tbl[21] = mk(0, 4'hA, 4'h2, DEF,          4'h2, 1, 8'h44, 8'hBB, 13, 0);
    tbl[22] = mk(0, 4'h1, 4'h0, DEF,          4'h1, 0, 8'h44, 8'hBB, 13, 0);
    tbl[23] = mk(0, 4'h2, 4'h0, 32'h44A522FF, 4'h2, 1, 8'h44, 8'hBB, 13, 0);  // owner 0 drop, FF
    tbl[24] = mk(0, 4'h2, 4'h2, 32'h44A56611, 4'h2, 1, 8'h66, 8'h99, 14, 0);
    tbl[25] = mk(1, 4'h2, 4'h2, 32'h44A56611, 4'h0, 0, 8'h00, 8'h00, 0,  0);  // reset mid-lock
    tbl[26] = mk(0, 4'hF, 4'h0, DEF,          4'h1, 0, 8'h00, 8'h00, 0,  0);  // pointer back at 0

    for (int i = 0; i < 27; i++) begin
      apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].req, tbl[i].lock, tbl[i].data, tbl[i].e);
    end

    // All four requesting and locked: each owns exactly 4 cycles in turn, and
    // o_q shows the previous cycle's owner data.
    e = '{gnt: 4'h0, own: 2'd0, q: 8'h00, qbar: 8'h00, wcnt: 16'd0, abort: 1'b0};
    apply("lockrot rst", 1'b1, 4'hF, 4'hF, DEF, e);
    dv = DEF;
    for (int n = 1; n <= 17; n++) begin
      own     = ((n - 1) / 4) % 4;
      e.gnt   = 4'(1 << own);
      e.own   = 2'(own);
      e.q     = (n == 1) ? 8'h00 : dv[8 * (((n - 2) / 4) % 4) +: 8];
      e.qbar  = (n == 1) ? 8'h00 : ~e.q;
      e.wcnt  = 16'(n - 1);
      e.abort = (n > 1) && ((n - 1) % 4 == 0);
      apply($sformatf("lockrot%0d", n), 1'b0, 4'hF, 4'hF, DEF, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter sharing one DATA_W-bit output register pair (o_q / o_qbar, true + complement) between NUM_REQ requesters.
- Registered one-hot grant, optional per-requester lock for bounded burst ownership, register write only by the current owner.
- Sits between several producer blocks and a single shared status/data register on the iCE40 fabric.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of each requester's data and of o_q/o_qbar.
- MAX_HOLD, 4, max consecutive grant cycles per ownership when locked (>=1).

Ports:
- i_clk  input  1  clock, all logic on posedge.
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  NUM_REQ  request, one bit per requester.
- i_lock  input  NUM_REQ  per-requester lock; meaningful only for the current owner.
- i_data  input  NUM_REQ*DATA_W  requester k data at bits [k*DATA_W +: DATA_W].
- o_gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle.
- o_gnt_valid  output  1  high when o_gnt is non-zero.
- o_owner  output  $clog2(NUM_REQ)  index of granted requester; 0 when idle.
- o_q  output  DATA_W  shared register.
- o_qbar  output  DATA_W  complement register.

Behaviour:
- Reset (i_rst high at edge): o_gnt=0, o_gnt_valid=0, o_owner=0, o_q=0, o_qbar=0, priority pointer=0, hold_cnt=0, state IDLE. Reset mid-grant drops grant immediately with no write that cycle. o_qbar==~o_q does not hold until the first write.
- States: IDLE (no grant), OWN (one grant asserted).
- Selection: first set i_req bit searching from pointer upward, wrapping mod NUM_REQ. It is computed combinationally and registered into o_gnt. Grant latency is 1 cycle from i_req sampled high.
- IDLE -> OWN: at an edge with any i_req set. Winner k: o_gnt[k]=1, o_owner=k, hold_cnt=0, pointer=k+1 mod NUM_REQ.
- Write rule: at each edge in OWN where i_req[owner]=1: o_q<=data_owner, o_qbar<=~data_owner, visible next cycle. No write in IDLE, and no write if the owner dropped i_req.
- OWN stay: i_req[owner]=1 and i_lock[owner]=1 and hold_cnt<MAX_HOLD-1: keep grant, hold_cnt++.
- OWN release: any other case (unlocked, owner dropped req, or hold_cnt reached MAX_HOLD-1).
  - If any i_req is set, the next owner is selected from the updated pointer in the same edge, giving back-to-back grants with no idle bubble. The previous owner can win again only if it is the sole requester.
  - Otherwise go to IDLE, clear o_gnt, hold o_q/o_qbar.
- An unlocked owner gets exactly one grant cycle per arbitration round.
- i_lock of non-owners is ignored. i_data of non-owners is never sampled.
- Fairness: with all requesters continuously requesting unlocked, grants rotate 0,1,2,...,NUM_REQ-1,0.

Optional Feature:
- Macro REG_WRITE_STATS_EN.
- Defined: adds output o_write_cnt (16 bits). Reset 0, +1 on every write edge, saturates at 16'hFFFF. Also adds output o_hold_abort (1 bit), pulsed for one cycle when a locked owner is released by the MAX_HOLD limit.
- Undefined: neither port nor the counter logic exists. Core behaviour is identical.

Test Plan:
- Reset: drive i_req=4'b1111 with i_rst=1 for 3 cycles -> o_gnt=0, o_q=0, o_qbar=0 throughout. First grant goes to requester 0 one cycle after i_rst falls.
- Single request: i_req=4'b0100, data2=8'hA5, unlocked -> o_gnt=4'b0100 one cycle later. Next cycle o_q=8'hA5, o_qbar=8'h5A. Grant re-issues to 2 each cycle while sole requester.
- Round-robin: i_req=4'b1111 held, no locks -> o_owner sequence 0,1,2,3,0 on consecutive cycles. o_q tracks each owner's data one cycle after its grant.
- Lock limit: MAX_HOLD=4, requester 1 locked and requesting, requester 3 requesting -> owner 1 for exactly 4 cycles, then owner 3. With REG_WRITE_STATS_EN, o_hold_abort pulses once.
- Owner drop: owner 0 drops i_req mid-grant with data0=8'hFF -> no write that edge, o_q retains its prior value. Grant moves to the next requester or IDLE.
- Reset mid-lock: i_rst asserted during a locked ownership -> next cycle o_gnt=0, o_q=0, pointer=0. REG_WRITE_STATS_EN build: o_write_cnt=0.
